serial_link_credit_rx_queue: RTL and testbench
==============================================

SERIAL_LINK_CREDIT_RX_QUEUE -- requirements
Module: serial_link_credit_rx_queue

Interface
REQ-001 SHALL have parameter DataWidth, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter CreditWidth, default 8, meaning width of the credit field and of all credit counts.
REQ-003 SHALL have parameter NumCredits, default 8, meaning queue depth; it equals the credits granted to the remote sender.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rx_valid_i, input, 1, meaning an incoming link packet is present this cycle; there is no ready, so every packet is taken.
REQ-007 SHALL have port rx_data_i, input, DataWidth, meaning packet payload.
REQ-008 SHALL have port rx_credits_i, input, CreditWidth, meaning credits returned by the remote side.
REQ-009 SHALL have port rx_credits_only_i, input, 1, meaning the packet carries credits only and no payload.
REQ-010 SHALL have port receive_cred_o, input-side of the credit counter, output, 1, meaning credits_received_o is valid this cycle.
REQ-011 SHALL have port credits_received_o, output, CreditWidth, meaning credits extracted from the packet.
REQ-012 SHALL have port out_valid_o, output, 1, meaning the queue head is valid toward the sink.
REQ-013 SHALL have port out_data_o, output, DataWidth, meaning the queue head payload.
REQ-014 SHALL have port out_ready_i, input, 1, meaning the sink accepts the head.
REQ-015 SHALL have port usage_o, output, $clog2(NumCredits+1), meaning the current fill level.
REQ-016 SHALL have port overflow_o, output, 1, meaning a sticky overflow error.

Function
REQ-017 SHALL compute push = rx_valid_i & ~rx_credits_only_i, and pop = out_valid_o & out_ready_i.
REQ-018 SHALL register credits with one cycle of latency: receive_cred_o equals rx_valid_i from the previous cycle, for both credits-only and data packets; credits_received_o equals that cycle's rx_credits_i.
REQ-019 SHALL drive credits_received_o to 0 whenever receive_cred_o is 0.
REQ-020 SHALL implement a circular buffer of NumCredits entries with write and read pointers that wrap from NumCredits-1 to 0, including for non-power-of-two depths.
REQ-021 SHALL have no fall-through: data pushed in cycle N is visible on out_data_o with out_valid_o=1 at cycle N+1 at the earliest.
REQ-022 SHALL hold out_data_o stable while out_valid_o=1 and out_ready_i=0.
REQ-023 SHALL assert out_valid_o iff usage_o > 0.
REQ-024 SHALL, on a simultaneous push and pop, leave usage unchanged and advance both pointers.
REQ-025 SHALL, on a simultaneous push and pop while full, accept the push because the pop frees the slot in the same cycle.
REQ-026 SHALL, on a push while full without a pop, drop the packet, leave the pointers and usage unchanged, and set overflow_o.
REQ-027 SHALL still forward the credits of a dropped packet per REQ-018.
REQ-028 SHALL keep overflow_o set until reset.
REQ-029 SHALL ignore a pop when the queue is empty; this case cannot occur because out_valid_o=0.
REQ-030 SHALL keep usage_o at or below NumCredits at all times.
REQ-031 SHALL not modify or inspect the payload.

Reset
REQ-032 SHALL, with rst_i=1 at a clock edge, clear the pointers, usage_o, overflow_o, receive_cred_o and credits_received_o to 0, which forces out_valid_o=0.
REQ-033 SHALL, on reset mid-operation, discard all queued entries and any credits in flight; no handshake outputs are asserted in the cycle following reset.
REQ-034 SHALL leave the buffer storage contents unreset; out_data_o is don't-care while out_valid_o=0.

Verification
REQ-035 SHALL cover credit extraction: a credits-only packet with credits=5 -> next cycle receive_cred_o=1, credits_received_o=5; usage_o stays 0 and out_valid_o stays 0.
REQ-036 SHALL cover ordering and latency: push 0xA1, 0xA2, 0xA3 back-to-back with out_ready_i=1 -> outputs 0xA1, 0xA2, 0xA3 in order, first at one cycle after its push.
REQ-037 SHALL cover full plus simultaneous push/pop: fill 8 entries with ready low, then push and pop in the same cycle -> usage_o stays 8, overflow_o=0, ninth datum delivered last.
REQ-038 SHALL cover overflow: with 8 entries and ready low, push 0xFF carrying credits=2 -> overflow_o=1, usage_o=8, 0xFF never output, credits_received_o=2 next cycle.
REQ-039 SHALL cover backpressure and wrap-around: random out_ready_i over 1000 packets with NumCredits=5 -> no loss, no duplication, data stable while stalled.
REQ-040 SHALL cover reset mid-stream: with 3 queued entries, assert rst_i for one cycle -> usage_o=0, out_valid_o=0, overflow_o=0, receive_cred_o=0.

Source files
------------

// File: rtl/serial_link_credit_rx_queue.sv
// Receive side of a credit-based serial link: every packet's credits are
// forwarded one cycle later, payload packets are buffered in a circular queue.
module serial_link_credit_rx_queue #(
    parameter int DataWidth   = 32,
    parameter int CreditWidth = 8,
    parameter int NumCredits  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            rx_valid_i,
    input  logic [DataWidth-1:0]            rx_data_i,
    input  logic [CreditWidth-1:0]          rx_credits_i,
    input  logic                            rx_credits_only_i,
    output logic                            receive_cred_o,
    output logic [CreditWidth-1:0]          credits_received_o,
    output logic                            out_valid_o,
    output logic [DataWidth-1:0]            out_data_o,
    input  logic                            out_ready_i,
    output logic [$clog2(NumCredits+1)-1:0] usage_o,
    output logic                            overflow_o
);

    localparam int PtrWidth   = (NumCredits > 1) ? $clog2(NumCredits) : 1;
    localparam int UsageWidth = $clog2(NumCredits + 1);

    logic [DataWidth-1:0]  mem [NumCredits];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [PtrWidth-1:0]   wr_ptr_next;
    logic [PtrWidth-1:0]   rd_ptr_next;
    logic [UsageWidth-1:0] usage;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  accept;

    // out_valid_o/out_ready_i: a head entry transfers on a rising edge where
    // both are high; valid never depends on ready, and the head holds until taken.
    assign push   = rx_valid_i & ~rx_credits_only_i;
    assign pop    = out_valid_o & out_ready_i;
    assign full   = (usage == UsageWidth'(NumCredits));
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign accept = push & (~full | pop);

    assign wr_ptr_next = (wr_ptr == PtrWidth'(NumCredits - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_next = (rd_ptr == PtrWidth'(NumCredits - 1)) ? '0 : rd_ptr + 1'b1;

    assign out_valid_o = (usage != '0);
    assign out_data_o  = mem[rd_ptr];
    assign usage_o     = usage;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            usage              <= '0;
            overflow_o         <= 1'b0;
            receive_cred_o     <= 1'b0;
            credits_received_o <= '0;
        end else begin
            receive_cred_o     <= rx_valid_i;
            credits_received_o <= rx_valid_i ? rx_credits_i : '0;
            if (accept) begin
                wr_ptr <= wr_ptr_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_next;
            end
            case ({accept, pop})
                2'b10:   usage <= usage + 1'b1;
                2'b01:   usage <= usage - 1'b1;
                default: usage <= usage;
            endcase
            if (push & full & ~pop) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // Storage is deliberately left unreset; only entries below usage are observable.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr] <= rx_data_i;
        end
    end

endmodule

// File: tb/tb_serial_link_credit_rx_queue.sv
// Directed checks on an 8-deep queue plus a randomised backpressure run on a 5-deep one.
module tb_serial_link_credit_rx_queue;

    logic        clk;
    logic        rst;

    // 8-entry instance
    logic        rx_valid;
    logic [31:0] rx_data;
    logic [7:0]  rx_credits;
    logic        rx_credits_only;
    logic        receive_cred;
    logic [7:0]  credits_received;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [3:0]  usage;
    logic        overflow;

    // 5-entry instance
    logic        rx_valid_b;
    logic [31:0] rx_data_b;
    logic [7:0]  rx_credits_b;
    logic        rx_credits_only_b;
    logic        receive_cred_b;
    logic [7:0]  credits_received_b;
    logic        out_valid_b;
    logic [31:0] out_data_b;
    logic        out_ready_b;
    logic [2:0]  usage_b;
    logic        overflow_b;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_q[$];

    serial_link_credit_rx_queue #(.DataWidth(32), .CreditWidth(8), .NumCredits(8)) u_dut8 (
        .clk_i              (clk),
        .rst_i              (rst),
        .rx_valid_i         (rx_valid),
        .rx_data_i          (rx_data),
        .rx_credits_i       (rx_credits),
        .rx_credits_only_i  (rx_credits_only),
        .receive_cred_o     (receive_cred),
        .credits_received_o (credits_received),
        .out_valid_o        (out_valid),
        .out_data_o         (out_data),
        .out_ready_i        (out_ready),
        .usage_o            (usage),
        .overflow_o         (overflow)
    );

    serial_link_credit_rx_queue #(.DataWidth(32), .CreditWidth(8), .NumCredits(5)) u_dut5 (
        .clk_i              (clk),
        .rst_i              (rst),
        .rx_valid_i         (rx_valid_b),
        .rx_data_i          (rx_data_b),
        .rx_credits_i       (rx_credits_b),
        .rx_credits_only_i  (rx_credits_only_b),
        .receive_cred_o     (receive_cred_b),
        .credits_received_o (credits_received_b),
        .out_valid_o        (out_valid_b),
        .out_data_o         (out_data_b),
        .out_ready_i        (out_ready_b),
        .usage_o            (usage_b),
        .overflow_o         (overflow_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic co, input logic [31:0] d,
                         input logic [7:0] c, input logic rdy);
        rx_valid        = v;
        rx_credits_only = co;
        rx_data         = d;
        rx_credits      = c;
        out_ready       = rdy;
    endtask

    task automatic fill8(input logic [31:0] base);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, base + 32'(i), 8'd0, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
    endtask

    task automatic drain8(input string tag, input logic [31:0] first[8]);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check({tag, "_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_data"}, 64'(out_data), 64'(first[i]));
            step();
        end
        check({tag, "_empty"}, 64'(out_valid), 64'd0);
        check({tag, "_usage0"}, 64'(usage), 64'd0);
    endtask

    initial begin
        logic [31:0] order[8];
        int          cnt;
        int          sent;
        int          cycles;
        logic        stalled;
        logic [31:0] held;
        logic        prev_v;
        logic [7:0]  prev_c;
        logic        do_push;
        logic [31:0] d;

        tests_run    = 0;
        tests_failed = 0;
        drive(1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
        rx_valid_b = 1'b0; rx_data_b = '0; rx_credits_b = '0;
        rx_credits_only_b = 1'b0; out_ready_b = 1'b0;

        // reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_usage", 64'(usage), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_rcred", 64'(receive_cred), 64'd0);
        check("rst_credits", 64'(credits_received), 64'd0);

        // credits-only packet
        drive(1'b1, 1'b1, 32'hDEAD, 8'd5, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'd0, 8'd9, 1'b1);
        check("cred_rcred", 64'(receive_cred), 64'd1);
        check("cred_value", 64'(credits_received), 64'd5);
        check("cred_usage", 64'(usage), 64'd0);
        check("cred_valid", 64'(out_valid), 64'd0);
        step();
        check("cred_idle_rcred", 64'(receive_cred), 64'd0);
        check("cred_idle_value", 64'(credits_received), 64'd0);

        // ordering and one-cycle latency
        drive(1'b1, 1'b0, 32'hA1, 8'd0, 1'b1);
        check("lat_none_before", 64'(out_valid), 64'd0);
        step();
        check("ord_v1", 64'(out_valid), 64'd1);
        check("ord_d1", 64'(out_data), 64'hA1);
        drive(1'b1, 1'b0, 32'hA2, 8'd0, 1'b1);
        step();
        check("ord_d2", 64'(out_data), 64'hA2);
        drive(1'b1, 1'b0, 32'hA3, 8'd0, 1'b1);
        step();
        check("ord_d3", 64'(out_data), 64'hA3);
        check("ord_usage1", 64'(usage), 64'd1);
        drive(1'b0, 1'b0, 32'd0, 8'd0, 1'b1);
        step();
        check("ord_empty", 64'(out_valid), 64'd0);

        // full plus simultaneous push/pop
        fill8(32'hB0);
        check("full_usage", 64'(usage), 64'd8);
        check("full_hold", 64'(out_data), 64'hB0);
        step();
        check("full_stable", 64'(out_data), 64'hB0);
        drive(1'b1, 1'b0, 32'hC9, 8'd0, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
        check("pp_usage", 64'(usage), 64'd8);
        check("pp_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 7; i++) order[i] = 32'hB1 + 32'(i);
        order[7] = 32'hC9;
        drain8("pp_drain", order);

        // overflow drops the packet but forwards its credits
        fill8(32'hD0);
        drive(1'b1, 1'b0, 32'hFF, 8'd2, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_usage", 64'(usage), 64'd8);
        check("ovf_rcred", 64'(receive_cred), 64'd1);
        check("ovf_credits", 64'(credits_received), 64'd2);
        for (int i = 0; i < 8; i++) order[i] = 32'hD0 + 32'(i);
        drain8("ovf_drain", order);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // reset mid-stream with credits in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'hE0 + 32'(i), 8'd1, 1'b0);
            step();
        end
        check("mid_usage3", 64'(usage), 64'd3);
        drive(1'b1, 1'b1, 32'd0, 8'd7, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
        check("mid_usage", 64'(usage), 64'd0);
        check("mid_valid", 64'(out_valid), 64'd0);
        check("mid_overflow", 64'(overflow), 64'd0);
        check("mid_rcred", 64'(receive_cred), 64'd0);
        check("mid_credits", 64'(credits_received), 64'd0);
        step();
        check("mid_after_rcred", 64'(receive_cred), 64'd0);
        check("mid_after_valid", 64'(out_valid), 64'd0);

        // random backpressure and wrap-around on the 5-deep queue
        cnt = 0; sent = 0; cycles = 0; stalled = 1'b0; held = '0;
        prev_v = 1'b0; prev_c = '0;
        while ((sent < 1000 || cnt > 0) && cycles < 20000) begin
            check("rnd_rcred", 64'(receive_cred_b), 64'(prev_v));
            check("rnd_credits", 64'(credits_received_b), prev_v ? 64'(prev_c) : 64'd0);
            check("rnd_usage", 64'(usage_b), 64'(cnt));
            check("rnd_valid", 64'(out_valid_b), 64'(cnt > 0));
            if (stalled) check("rnd_stable", 64'(out_data_b), 64'(held));
            out_ready_b = ($urandom_range(0, 2) != 0) || (sent >= 1000);
            if (out_valid_b && out_ready_b && exp_q.size() > 0) begin
                check("rnd_data", 64'(out_data_b), 64'(exp_q.pop_front()));
                cnt--;
            end
            rx_valid_b        = (sent < 1000) && ($urandom_range(0, 3) != 0);
            rx_credits_only_b = ($urandom_range(0, 4) == 0);
            rx_credits_b      = 8'($urandom_range(0, 255));
            d                 = {16'($urandom_range(0, 65535)), 16'(sent)};
            rx_data_b         = d;
            do_push = rx_valid_b && !rx_credits_only_b && (cnt < 5 || out_ready_b);
            if (rx_valid_b && !rx_credits_only_b && !do_push) rx_credits_only_b = 1'b1;
            if (do_push) begin
                exp_q.push_back(d);
                cnt++;
                sent++;
            end
            stalled = out_valid_b && !out_ready_b;
            held    = out_data_b;
            prev_v  = rx_valid_b;
            prev_c  = rx_credits_b;
            step();
            cycles++;
        end
        rx_valid_b = 1'b0;
        check("rnd_timeout", 64'(cycles < 20000), 64'd1);
        check("rnd_sent", 64'(sent), 64'd1000);
        check("rnd_leftover", 64'(exp_q.size()), 64'd0);
        check("rnd_final_usage", 64'(usage_b), 64'd0);
        check("rnd_overflow", 64'(overflow_b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
